// File: rtl/vga_fifo_reader_if.sv
// Purpose: bundles the read-FIFO handshake and the VGA DAC pins of vga_fifo_reader.
// Latency: none, wires only.
// Backpressure: none; the FIFO side is a plain empty/read-enable pair.
interface vga_fifo_reader_if;
    logic        empty_r;
    logic [15:0] fifo_dout;
    logic        ren;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [15:0] vga_rgb;
    logic        frame_start;
    logic [15:0] underflow_cnt;

    // Display reader side: consumes FIFO data, drives the DAC pins.
    modport master (
        input  empty_r, fifo_dout,
        output ren, vga_hs, vga_vs, vga_de, vga_rgb, frame_start, underflow_cnt
    );

    // Environment side: owns the FIFO, watches the DAC pins.
    modport slave (
        output empty_r, fifo_dout,
        input  ren, vga_hs, vga_vs, vga_de, vga_rgb, frame_start, underflow_cnt
    );
endinterface

// File: rtl/vga_fifo_reader.sv
// Purpose: VGA raster generator that pops one RGB565 word per active pixel from a non-FWFT read FIFO.
// Latency: sync/DE/RGB appear 2 clocks after the raster counters; ren is combinational.
// Backpressure: none; the raster never stalls, an empty FIFO yields FILL_RGB and bumps underflow_cnt.
module vga_fifo_reader #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0,
    parameter logic [15:0] FILL_RGB = 16'h0000
) (
    input  logic            r_clk,
    input  logic            rst,
    vga_fifo_reader_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare value of headroom so every window edge constant fits the counter.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0]   UF_MAX     = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_FRM = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    state_e state_q;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    logic de_pre, hs_pre, vs_pre, at_origin, run_now, ren_c, underflow_c;

    // Stage 1: timing qualifiers and the pop flag that matches next clock's fifo_dout.
    logic de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, ren1_q, ren1_d, fs1_q, fs1_d;
    // Stage 2: registered pins.
    logic        vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, vga_de_q, vga_de_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] vga_rgb_q, vga_rgb_d;
    logic [15:0] uf_cnt_q, uf_cnt_d;

    // Free-running raster counters: h wraps every line, v advances on h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Raster qualifiers and the FIFO pop decision for the current pixel.
    always_comb begin
        de_pre    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        hs_pre    = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vs_pre    = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        // The WAIT_FRM->RUN clock already owns pixel (0,0), so it counts as running.
        run_now   = (state_q == ST_RUN) || ((state_q == ST_WAIT_FRM) && at_origin);
        // Reset gates both so nothing is popped or counted in the reset clock.
        ren_c       = run_now && de_pre && !bus.empty_r && !rst;
        underflow_c = run_now && de_pre &&  bus.empty_r && !rst;
    end

    // Next values for both pipeline stages and the saturating underflow counter.
    always_comb begin
        de1_d  = de_pre;
        hs1_d  = hs_pre;
        vs1_d  = vs_pre;
        ren1_d = ren_c;
        fs1_d  = run_now && at_origin;

        vga_hs_d      = hs1_q;
        vga_vs_d      = vs1_q;
        vga_de_d      = de1_q;
        frame_start_d = fs1_q;
        // fifo_dout is valid exactly one clock after ren, i.e. while ren1_q is set.
        vga_rgb_d     = ren1_q ? bus.fifo_dout : (de1_q ? FILL_RGB : 16'h0000);

        uf_cnt_d = uf_cnt_q;
        if (underflow_c && (uf_cnt_q != UF_MAX)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    // Start-up FSM: wait for data, then align the first pop to the top-left pixel.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (!bus.empty_r) state_q <= ST_WAIT_FRM;
                ST_WAIT_FRM: if (at_origin)    state_q <= ST_RUN;
                ST_RUN:      state_q <= ST_RUN;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Counters, pipeline and statistics registers; reset aborts the frame at once.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            de1_q         <= 1'b0;
            hs1_q         <= ~SYNC_POL;
            vs1_q         <= ~SYNC_POL;
            ren1_q        <= 1'b0;
            fs1_q         <= 1'b0;
            vga_hs_q      <= ~SYNC_POL;
            vga_vs_q      <= ~SYNC_POL;
            vga_de_q      <= 1'b0;
            vga_rgb_q     <= 16'h0000;
            frame_start_q <= 1'b0;
            uf_cnt_q      <= 16'h0000;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            de1_q         <= de1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            ren1_q        <= ren1_d;
            fs1_q         <= fs1_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_de_q      <= vga_de_d;
            vga_rgb_q     <= vga_rgb_d;
            frame_start_q <= frame_start_d;
            uf_cnt_q      <= uf_cnt_d;
        end
    end

    assign bus.ren           = ren_c;
    assign bus.vga_hs        = vga_hs_q;
    assign bus.vga_vs        = vga_vs_q;
    assign bus.vga_de        = vga_de_q;
    assign bus.vga_rgb       = vga_rgb_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Purpose: directed self-checking bench for vga_fifo_reader on a shrunken raster plus a saturation instance.
// Latency: expects outputs 2 clocks after the raster position, ren in the same clock.
// Backpressure: models a non-FWFT FIFO whose empty flag is scheduled per clock.
module tb_vga_fifo_reader;
    // Main instance: 22 x 10 total, 16 x 6 active, hsync x=18..20, vsync y=7..8.
    localparam int HA = 16, HF = 2, HS = 3, HB = 1, HT = 22;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = 10;
    localparam logic [15:0] FILL = 16'hF81F;

    // Hand-derived schedule (cycle 0 = first clock after reset release, frame = 220 clocks).
    localparam int EN_C   = 445;   // FIFO gets data mid frame 2
    localparam int RUN1_C = 660;   // next (0,0): start of frame 3
    localparam int UF_BEG = 927;   // frame 4, line 2, x=3
    localparam int UF_END = 936;   // x=12 -> 10 starved pixels
    localparam int RST_C  = 1173;  // frame 5, line 3, x=7
    localparam int RUN2_C = 1394;  // one full frame after the reset restart
    localparam int N_CYC  = 1640;

    logic r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    logic rst   = 1'b1;
    logic rst_s = 1'b1;

    vga_fifo_reader_if bus ();
    vga_fifo_reader_if sbus ();

    vga_fifo_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .FILL_RGB(FILL)
    ) dut (
        .r_clk(r_clk),
        .rst  (rst),
        .bus  (bus)
    );

    // Nearly all-active raster so 65k+ underflows fit in a short run.
    vga_fifo_reader #(
        .H_ACTIVE(40), .H_FP(0), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(40), .V_FP(0), .V_SYNC(1), .V_BP(0),
        .SYNC_POL(1'b0), .FILL_RGB(16'h0000)
    ) dut_sat (
        .r_clk(r_clk),
        .rst  (rst_s),
        .bus  (sbus)
    );

    int checks    = 0;
    int failures  = 0;
    bit sat_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        logic [15:0] w;
        w = 16'(i);
        return 16'h4000 + w;
    endfunction

    function automatic bit in_run(input int k);
        return ((k >= RUN1_C) && (k < RST_C)) || (k >= RUN2_C);
    endfunction

    // Raster origin restarts on the clock after the reset clock.
    function automatic int pbase(input int k);
        return (k > RST_C) ? (RST_C + 1) : 0;
    endfunction

    bit          eren_hist [0:N_CYC-1];
    logic [15:0] eword     [0:N_CYC-1];

    int ptr        = 0;
    int mpops      = 0;
    int first_ren  = -1;
    int first_ren2 = -1;
    int fs_cnt     = 0;
    int de_f0      = 0;

    // Main instance: per-clock checks of pins, ren and the pixel stream.
    initial begin
        bus.empty_r   = 1'b1;
        bus.fifo_dout = 16'h0000;
        rst = 1'b1;
        repeat (3) @(posedge r_clk);
        for (int c = 0; c < N_CYC; c++) begin
            int p, k, x, y;
            bit de_e, hs_e, vs_e, fs_e, emp, eren, pop;
            logic [15:0] rgb_e;
            @(negedge r_clk);
            if ((c - pbase(c)) < 2) begin
                check($sformatf("rst_hs@%0d", c),  32'(bus.vga_hs), 32'd1);
                check($sformatf("rst_vs@%0d", c),  32'(bus.vga_vs), 32'd1);
                check($sformatf("rst_de@%0d", c),  32'(bus.vga_de), 32'd0);
                check($sformatf("rst_rgb@%0d", c), 32'(bus.vga_rgb), 32'd0);
                check($sformatf("rst_fs@%0d", c),  32'(bus.frame_start), 32'd0);
            end else begin
                k = c - 2;
                p = k - pbase(k);
                x = p % HT;
                y = (p / HT) % VT;
                de_e  = (x < HA) && (y < VA);
                hs_e  = !((x >= 18) && (x < 21));
                vs_e  = !((y >= 7) && (y < 9));
                fs_e  = in_run(k) && (x == 0) && (y == 0);
                rgb_e = eren_hist[k] ? eword[k] : (de_e ? FILL : 16'h0000);
                check($sformatf("hs@%0d", c),  32'(bus.vga_hs), 32'(hs_e));
                check($sformatf("vs@%0d", c),  32'(bus.vga_vs), 32'(vs_e));
                check($sformatf("de@%0d", c),  32'(bus.vga_de), 32'(de_e));
                check($sformatf("rgb@%0d", c), 32'(bus.vga_rgb), 32'(rgb_e));
                check($sformatf("fs@%0d", c),  32'(bus.frame_start), 32'(fs_e));
            end
            if ((c < 222) && (bus.vga_de === 1'b1)) de_f0++;
            if (bus.frame_start === 1'b1) fs_cnt++;

            if (c == 875)       check("uf_after_full_frame", 32'(bus.underflow_cnt), 32'd0);
            if (c == 1100)      check("uf_after_starve",     32'(bus.underflow_cnt), 32'd10);
            if (c == 1170)      check("uf_before_rst",       32'(bus.underflow_cnt), 32'd10);
            if (c == RST_C + 1) check("uf_after_rst",        32'(bus.underflow_cnt), 32'd0);
            if (c == N_CYC - 1) check("uf_end",              32'(bus.underflow_cnt), 32'd0);

            // Drive this clock's inputs and the reference pop decision.
            rst = (c == RST_C);
            emp = (c < EN_C) || ((c >= UF_BEG) && (c <= UF_END)) || (ptr >= 4096);
            bus.empty_r = emp;
            p = c - pbase(c);
            x = p % HT;
            y = (p / HT) % VT;
            eren = in_run(c) && (x < HA) && (y < VA) && !emp;
            eren_hist[c] = eren;
            eword[c]     = eren ? word(mpops) : 16'h0000;
            if (eren) mpops++;
            #1;
            check($sformatf("ren@%0d", c), 32'(bus.ren), 32'(eren));
            pop = (bus.ren === 1'b1);
            if (pop && (first_ren < 0)) first_ren = c;
            if (pop && (c > RST_C) && (first_ren2 < 0)) first_ren2 = c;

            // Non-FWFT FIFO: popped word appears on fifo_dout after the edge.
            @(posedge r_clk);
            #1;
            if (pop) begin
                bus.fifo_dout = word(ptr);
                ptr++;
            end
        end
        rst = 1'b0;
        check("first_ren_cycle",       32'(first_ren),  32'(RUN1_C));
        check("first_ren_after_reset", 32'(first_ren2), 32'(RUN2_C));
        check("frame_start_pulses",    32'(fs_cnt),     32'd5);
        check("de_clks_frame0",        32'(de_f0),      32'd96);
        check("pops_total",            32'(ptr),        32'(mpops));
        wait (sat_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Saturation instance: permanently starved once running.
    initial begin
        int  sc;
        int  sren;
        bit  reached;
        sbus.empty_r   = 1'b0;
        sbus.fifo_dout = 16'h0000;
        rst_s = 1'b1;
        repeat (3) @(posedge r_clk);
        sc = 0;
        sren = 0;
        reached = 1'b0;
        @(negedge r_clk);
        rst_s = 1'b0;
        check("sat_uf_reset", 32'(sbus.underflow_cnt), 32'd0);
        while (!reached && (sc < 80000)) begin
            sbus.empty_r = (sc >= 2);
            #1;
            if (sbus.ren === 1'b1) sren++;
            if (sbus.underflow_cnt >= 16'd65530) begin
                reached = 1'b1;
            end else begin
                @(negedge r_clk);
                sc++;
            end
        end
        check("sat_reached", 32'(reached), 32'd1);
        check("sat_at_65530", 32'(sbus.underflow_cnt), 32'd65530);
        repeat (20) @(negedge r_clk);
        check("sat_hold_a", 32'(sbus.underflow_cnt), 32'h0000FFFF);
        repeat (100) @(negedge r_clk);
        check("sat_hold_b", 32'(sbus.underflow_cnt), 32'h0000FFFF);
        check("sat_no_ren", 32'(sren), 32'd0);
        sat_done = 1'b1;
    end

endmodule
